// File: rtl/wptr_full_pkg.sv
// rtl/wptr_full_pkg.sv - shared async-FIFO depth and Gray-code helpers
package wptr_full_pkg;

    localparam int unsigned CODE_W = 32;

    function automatic int fifo_depth(input int addrsize);
        return 1 << addrsize;
    endfunction

    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Zero-extended Gray codes convert correctly, so narrower pointers can use this too.
    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
        logic [CODE_W-1:0] b;
        for (int i = 0; i < CODE_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_if.sv
// rtl/wptr_full_if.sv - write-side pointer/flag bundle of the async FIFO
interface wptr_full_if #(
    parameter int ADDRSIZE = 4
);
    logic                winc;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE-1:0] waddr;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE:0]   wlevel;
    logic                wovf;

    modport master (
        output winc, wq2_rptr,
        input  wptr, waddr, wfull, walmost_full, wlevel, wovf
    );

    modport slave (
        input  winc, wq2_rptr,
        output wptr, waddr, wfull, walmost_full, wlevel, wovf
    );
endinterface

// File: rtl/wptr_full_gray2bin.sv
// rtl/wptr_full_gray2bin.sv - combinational Gray-to-binary XOR prefix
module wptr_full_gray2bin #(
    parameter int N = 5
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < N; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/wptr_full.sv
// rtl/wptr_full.sv - async FIFO write pointer, full/almost-full, level and overflow
module wptr_full
    import wptr_full_pkg::*;
#(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = fifo_depth(ADDRSIZE) - 2
) (
    input  logic         wclk,
    input  logic         wrst_n,
    wptr_full_if.slave   bus
);

    localparam int AW = ADDRSIZE;
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_THRESH);

    logic [AW:0] wbin;
    logic [AW:0] wbnext;
    logic [AW:0] wgnext;
    logic [AW:0] rbin_s;
    logic [AW:0] level_next;
    logic [AW:0] wptr_q;
    logic [AW:0] wlevel_q;
    logic        wfull_q;
    logic        afull_q;
    logic        wovf_q;
    logic        winc_ok;
    logic        full_next;

    wptr_full_gray2bin #(
        .N (AW + 1)
    ) u_rptr_g2b (
        .gray (bus.wq2_rptr),
        .bin  (rbin_s)
    );

    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    always_comb begin
        winc_ok    = bus.winc & ~wfull_q;
        wbnext     = wbin + (AW+1)'(winc_ok);
        wgnext     = (wbnext >> 1) ^ wbnext;
        level_next = wbnext - rbin_s;
        full_next  = (wgnext == {~bus.wq2_rptr[AW:AW-1], bus.wq2_rptr[AW-2:0]});
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin     <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            afull_q  <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wbin     <= wbnext;
            wptr_q   <= wgnext;
            wfull_q  <= full_next;
            afull_q  <= (level_next >= AFULL_LVL);
            wlevel_q <= level_next;
            wovf_q   <= wovf_q | (bus.winc & wfull_q);
        end
    end

    assign bus.wptr         = wptr_q;
    assign bus.waddr        = wbin[AW-1:0];
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = afull_q;
    assign bus.wlevel       = wlevel_q;
    assign bus.wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// tb/tb_wptr_full.sv - directed bench for wptr_full (ADDRSIZE=4, AFULL_THRESH=12)
module tb_wptr_full;

    logic wclk;
    logic wrst_n;
    int   checks;
    int   errors;

    wptr_full_if #(.ADDRSIZE(4)) bus ();

    wptr_full #(
        .ADDRSIZE     (4),
        .AFULL_THRESH (12)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return (b >> 1) ^ b;
    endfunction

    // {wptr, waddr, wfull, walmost_full, wlevel, wovf}
    function automatic logic [16:0] pack_exp(input logic [4:0] p, input logic [3:0] a,
                                             input logic f, input logic af,
                                             input logic [4:0] l, input logic o);
        return {p, a, f, af, l, o};
    endfunction

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        logic [16:0] obs;
        wrst_n       = 1'b0;
        bus.winc     = 1'b0;
        bus.wq2_rptr = '0;
        #1;
        obs = {bus.wptr, bus.waddr, bus.wfull, bus.walmost_full, bus.wlevel, bus.wovf};
        checks++;
        if (obs !== 17'd0) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", obs, 17'd0);
        end
        tick();
        tick();
        wrst_n   = 1'b1;
        bus.winc = 1'b1;
        repeat (3) tick();
        bus.winc = 1'b0;
        obs = {bus.wptr, bus.waddr, bus.wfull, bus.walmost_full, bus.wlevel, bus.wovf};
        checks++;
        if (obs !== pack_exp(5'b00010, 4'd3, 1'b0, 1'b0, 5'd3, 1'b0)) begin
            errors++;
            $display("FAIL three_writes got %h exp %h", obs,
                     pack_exp(5'b00010, 4'd3, 1'b0, 1'b0, 5'd3, 1'b0));
        end
        #2;
        wrst_n = 1'b0;
        #1;
        obs = {bus.wptr, bus.waddr, bus.wfull, bus.walmost_full, bus.wlevel, bus.wovf};
        checks++;
        if (obs !== 17'd0) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", obs, 17'd0);
        end
        tick();
        wrst_n = 1'b1;
    endtask

    task automatic test_fill();
        bus.wq2_rptr = '0;
        bus.winc     = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (bus.wlevel !== 5'(k) || bus.walmost_full !== (k >= 12)) begin
                errors++;
                $display("FAIL fill_level_%0d got level %0d afull %0b exp level %0d afull %0b",
                         k, bus.wlevel, bus.walmost_full, k, (k >= 12));
            end
            checks++;
            if (bus.wfull !== (k == 16)) begin
                errors++;
                $display("FAIL fill_wfull_%0d got %0b exp %0b", k, bus.wfull, (k == 16));
            end
        end
        checks++;
        if ({bus.wptr, bus.waddr, bus.wovf} !== {5'b11000, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL fill_ptr got wptr %b waddr %0d wovf %0b exp wptr 11000 waddr 0 wovf 0",
                     bus.wptr, bus.waddr, bus.wovf);
        end
    endtask

    task automatic test_overflow();
        logic [16:0] obs;
        bus.winc = 1'b1;
        repeat (3) tick();
        obs = {bus.wptr, bus.waddr, bus.wfull, bus.walmost_full, bus.wlevel, bus.wovf};
        checks++;
        if (obs !== pack_exp(5'b11000, 4'd0, 1'b1, 1'b1, 5'd16, 1'b1)) begin
            errors++;
            $display("FAIL overflow_hold got %h exp %h", obs,
                     pack_exp(5'b11000, 4'd0, 1'b1, 1'b1, 5'd16, 1'b1));
        end
        bus.winc = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus.wovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky got %0b exp 1", bus.wovf);
        end
    endtask

    task automatic test_read_release();
        logic [16:0] obs;
        bus.wq2_rptr = gray(5'd4);
        tick();
        obs = {bus.wptr, bus.waddr, bus.wfull, bus.walmost_full, bus.wlevel, bus.wovf};
        checks++;
        if (obs !== pack_exp(5'b11000, 4'd0, 1'b0, 1'b1, 5'd12, 1'b1)) begin
            errors++;
            $display("FAIL release_12 got %h exp %h", obs,
                     pack_exp(5'b11000, 4'd0, 1'b0, 1'b1, 5'd12, 1'b1));
        end
        bus.wq2_rptr = gray(5'd5);
        tick();
        checks++;
        if ({bus.wlevel, bus.walmost_full, bus.wfull} !== {5'd11, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL release_11 got level %0d afull %0b full %0b exp level 11 afull 0 full 0",
                     bus.wlevel, bus.walmost_full, bus.wfull);
        end
    endtask

    task automatic test_wrap();
        logic [16:0] obs;
        bus.wq2_rptr = 5'b11000;
        bus.winc     = 1'b1;
        repeat (15) tick();
        obs = {bus.wptr, bus.waddr, bus.wfull, bus.walmost_full, bus.wlevel, bus.wovf};
        checks++;
        if (obs !== pack_exp(5'b10000, 4'd15, 1'b0, 1'b1, 5'd15, 1'b1)) begin
            errors++;
            $display("FAIL wrap_preload got %h exp %h", obs,
                     pack_exp(5'b10000, 4'd15, 1'b0, 1'b1, 5'd15, 1'b1));
        end
        tick();
        bus.winc = 1'b0;
        obs = {bus.wptr, bus.waddr, bus.wfull, bus.walmost_full, bus.wlevel, bus.wovf};
        checks++;
        if (obs !== pack_exp(5'b00000, 4'd0, 1'b1, 1'b1, 5'd16, 1'b1)) begin
            errors++;
            $display("FAIL wrap_full got %h exp %h", obs,
                     pack_exp(5'b00000, 4'd0, 1'b1, 1'b1, 5'd16, 1'b1));
        end
    endtask

    task automatic test_simultaneous();
        logic [16:0] obs;
        bus.wq2_rptr = gray(5'd17);
        tick();
        checks++;
        if ({bus.wlevel, bus.wfull} !== {5'd15, 1'b0}) begin
            errors++;
            $display("FAIL simul_setup got level %0d full %0b exp level 15 full 0",
                     bus.wlevel, bus.wfull);
        end
        bus.winc     = 1'b1;
        bus.wq2_rptr = gray(5'd18);
        tick();
        bus.winc = 1'b0;
        obs = {bus.wptr, bus.waddr, bus.wfull, bus.walmost_full, bus.wlevel, bus.wovf};
        checks++;
        if (obs !== pack_exp(5'b00001, 4'd1, 1'b0, 1'b1, 5'd15, 1'b1)) begin
            errors++;
            $display("FAIL simul_write_read got %h exp %h", obs,
                     pack_exp(5'b00001, 4'd1, 1'b0, 1'b1, 5'd15, 1'b1));
        end
    endtask

    task automatic test_reset_clears_ovf();
        logic [16:0] obs;
        #2;
        wrst_n = 1'b0;
        #1;
        obs = {bus.wptr, bus.waddr, bus.wfull, bus.walmost_full, bus.wlevel, bus.wovf};
        checks++;
        if (obs !== 17'd0) begin
            errors++;
            $display("FAIL reset_clears_ovf got %h exp %h", obs, 17'd0);
        end
        tick();
        wrst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_wrap();
        test_simultaneous();
        test_reset_clears_ovf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wptr_full.md
Name: wptr_full

Overview:
- Write-side pointer and full-flag logic of the async FIFO; mirror of the read-pointer/empty stage.
- Sits in the write clock domain.
- Drives the dual-port RAM write address and the Gray write pointer that the 2-flop synchroniser carries into the read domain.
- Consumes the read pointer already synchronised into the write domain. Adds fill level, almost-full and sticky overflow flags for upstream flow control.

Parameters:
ADDRSIZE, 4, RAM address width; FIFO depth = 2**ADDRSIZE; must be >= 2.
AFULL_THRESH, 2**ADDRSIZE-2, fill level at or above which walmost_full asserts; legal range 1..2**ADDRSIZE.

Ports:
wclk  input  1  write-domain clock.
wrst_n  input  1  asynchronous active-low reset, write domain.
winc  input  1  write request; takes effect only when wfull=0.
wq2_rptr  input  ADDRSIZE+1  Gray read pointer, already 2-flop synchronised into wclk.
wptr  output  ADDRSIZE+1  registered Gray write pointer, sent to the synchroniser.
waddr  output  ADDRSIZE  RAM write address = low ADDRSIZE bits of the binary write count.
wfull  output  1  registered full flag.
walmost_full  output  1  registered; 1 when fill level >= AFULL_THRESH.
wlevel  output  ADDRSIZE+1  registered fill level, 0..2**ADDRSIZE, as seen by the write side.
wovf  output  1  sticky overflow: set when winc=1 while wfull=1; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): wbin=0, wptr=0, waddr=0, wfull=0, walmost_full=0, wlevel=0, wovf=0.
- Internal binary count wbin is ADDRSIZE+1 bits.
- wbnext = wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1); wraps naturally, no saturation.
- wgnext = (wbnext>>1) ^ wbnext.
- All outputs update on the same wclk edge from "next" values, so a write is reflected with zero extra latency:
  - wbin<=wbnext
  - wptr<=wgnext
  - waddr=wbin[ADDRSIZE-1:0]: combinational from the register, the address used by the current write.
- Full: wfull <= (wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
- Level:
  - rbin_s = Gray-to-binary of wq2_rptr.
  - wlevel <= wbnext - rbin_s, modulo 2**(ADDRSIZE+1).
  - walmost_full <= (that same value >= AFULL_THRESH).
- wovf <= wovf | (winc & wfull).
- Write while full: wbin, wptr and waddr hold; wfull stays 1 unless the read pointer advanced.
- Simultaneous write and read-pointer advance: both are reflected in the same edge's level/full computation. Example: level held at 15 with one write and one read stays 15.
- Pessimism: flags are conservative because wq2_rptr lags by 2+ cycles. wfull/walmost_full may stay asserted extra cycles after reads, but never deassert early.
- wq2_rptr is assumed Gray-coded (single bit change per step); no checking in RTL.
- Reset mid-operation: all state returns to reset values immediately; wovf is cleared.

Decomposition:
- Shared async-FIFO package holds:
  - localparam-style depth function (2**ADDRSIZE);
  - bin2gray / gray2bin function definitions, also usable by the read side.
- One natural sub-module, gray2bin, parameterised width N = ADDRSIZE+1, purely combinational XOR-prefix. Instantiate it once for rbin_s.

Test Plan (ADDRSIZE=4, AFULL_THRESH=12):
1. Assert wrst_n=0 mid-stream -> all outputs 0 asynchronously, before the next wclk edge.
2. wq2_rptr=0, 16 consecutive winc -> after the 16th edge: wfull=1, wptr=5'b11000, wlevel=16, waddr=0; walmost_full=1 from the 12th edge.
3. From full, winc=1 for 3 cycles -> wptr, waddr and wlevel unchanged; wovf=1 and stays 1 after winc drops.
4. From full, set wq2_rptr=gray(4)=5'b00110 -> next edge wfull=0, wlevel=12, walmost_full=1. Then set gray(5)=5'b00111 -> wlevel=11, walmost_full=0.
5. Wrap:
   - Preload via writes/reads so that wbin=31 and wq2_rptr=gray(16)=5'b11000.
   - One write -> wbin=0, wptr=5'b00000, wfull=1, wlevel=16.
6. At level 15, winc=1 on the same edge as wq2_rptr advances by 1 -> wlevel stays 15, wfull=0, wptr advances by one Gray step.
